// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction-fetch controller
// Contents: default widths, NOP encoding, reset PC, PC word-index type and
// the next-PC select enum used by if_fetch_ctrl.
package fetch_pkg;

    localparam int          PC_W_DEF     = 5;
    localparam int          INST_W_DEF   = 32;
    localparam logic [31:0] NOP_INST     = 32'h0000_0000;
    localparam int          RESET_PC_DEF = 0;

    typedef logic [PC_W_DEF-1:0] pc_idx_t;

    typedef enum logic [1:0] {
        NPC_SEQ,
        NPC_HOLD,
        NPC_BR,
        NPC_JMP
    } npc_sel_e;

endpackage

// File: rtl/fetch_perf_cnt.sv
// rtl/fetch_perf_cnt.sv - 16-bit saturating event counter with synchronous reset
// Ports:
//   clk - rising-edge clock
//   rst - synchronous active-high clear
//   en  - count one event this cycle
//   cnt - current count, sticks at 16'hFFFF
module fetch_perf_cnt (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [15:0] cnt
);

    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 16'h0000;
        end else if (en && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'h0001;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// rtl/if_fetch_ctrl.sv - PC register, ROM addressing and IF/ID register with stall and redirect
// Optional feature macro: FETCH_PERF_EN (adds saturating fetch/stall/flush counters).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   stall                     - hold PC and IF/ID
//   br_taken, br_target       - taken branch from ID and its word index
//   jmp_en, jmp_target        - jump from ID and its word index
//   rom_addr / rom_inst       - combinational ROM index (= PC) and returned word
//   ifid_inst, ifid_pc,
//   ifid_pc_plus1, ifid_valid - IF/ID pipeline register
//   perf_*_cnt                - event counters (FETCH_PERF_EN only)
module if_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int PC_W     = PC_W_DEF,
    parameter int INST_W   = INST_W_DEF,
    parameter int RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_taken,
    input  logic [PC_W-1:0]   br_target,
    input  logic              jmp_en,
    input  logic [PC_W-1:0]   jmp_target,
    output logic [PC_W-1:0]   rom_addr,
    input  logic [INST_W-1:0] rom_inst,
    output logic [INST_W-1:0] ifid_inst,
    output logic [PC_W-1:0]   ifid_pc,
    output logic [PC_W-1:0]   ifid_pc_plus1,
    output logic              ifid_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]       perf_fetch_cnt,
    output logic [15:0]       perf_stall_cnt,
    output logic [15:0]       perf_flush_cnt
`endif
);

    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   pc_plus1;
    logic [INST_W-1:0] ifid_inst_q, ifid_inst_d;
    logic [PC_W-1:0]   ifid_pc_q, ifid_pc_d;
    logic [PC_W-1:0]   ifid_pc_plus1_q, ifid_pc_plus1_d;
    logic              ifid_valid_q, ifid_valid_d;
    npc_sel_e          npc_sel;

    // Natural modulo-2^PC_W wrap, 31 -> 0 for the default width.
    assign pc_plus1 = pc_q + PC_W'(1);
    assign rom_addr = pc_q;

    // Stall outranks redirect: ID re-presents a held branch, so dropping it here is safe.
    always_comb begin
        npc_sel = NPC_SEQ;
        if (stall) begin
            npc_sel = NPC_HOLD;
        end else if (br_taken) begin
            npc_sel = NPC_BR;
        end else if (jmp_en) begin
            npc_sel = NPC_JMP;
        end
    end

    always_comb begin
        pc_d            = pc_q;
        ifid_inst_d     = ifid_inst_q;
        ifid_pc_d       = ifid_pc_q;
        ifid_pc_plus1_d = ifid_pc_plus1_q;
        ifid_valid_d    = ifid_valid_q;
        unique case (npc_sel)
            NPC_HOLD: begin
            end
            NPC_BR, NPC_JMP: begin
                // The word currently on rom_inst is wrong-path; squash it to a bubble.
                pc_d            = (npc_sel == NPC_BR) ? br_target : jmp_target;
                ifid_inst_d     = INST_W'(NOP_INST);
                ifid_pc_d       = pc_q;
                ifid_pc_plus1_d = pc_plus1;
                ifid_valid_d    = 1'b0;
            end
            default: begin
                pc_d            = pc_plus1;
                ifid_inst_d     = rom_inst;
                ifid_pc_d       = pc_q;
                ifid_pc_plus1_d = pc_plus1;
                ifid_valid_d    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q            <= PC_W'(RESET_PC);
            ifid_inst_q     <= INST_W'(NOP_INST);
            ifid_pc_q       <= '0;
            ifid_pc_plus1_q <= '0;
            ifid_valid_q    <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            ifid_inst_q     <= ifid_inst_d;
            ifid_pc_q       <= ifid_pc_d;
            ifid_pc_plus1_q <= ifid_pc_plus1_d;
            ifid_valid_q    <= ifid_valid_d;
        end
    end

    assign ifid_inst     = ifid_inst_q;
    assign ifid_pc       = ifid_pc_q;
    assign ifid_pc_plus1 = ifid_pc_plus1_q;
    assign ifid_valid    = ifid_valid_q;

`ifdef FETCH_PERF_EN
    fetch_perf_cnt u_fetch_cnt (
        .clk (clk),
        .rst (rst),
        .en  (npc_sel == NPC_SEQ),
        .cnt (perf_fetch_cnt)
    );

    fetch_perf_cnt u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .en  (stall),
        .cnt (perf_stall_cnt)
    );

    fetch_perf_cnt u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .en  ((npc_sel == NPC_BR) || (npc_sel == NPC_JMP)),
        .cnt (perf_flush_cnt)
    );
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb/tb_if_fetch_ctrl.sv - self-checking bench for if_fetch_ctrl
module tb_if_fetch_ctrl;
    import fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    pc_idx_t     br_target = '0;
    logic        jmp_en = 1'b0;
    pc_idx_t     jmp_target = '0;
    pc_idx_t     rom_addr;
    logic [31:0] rom_inst;
    logic [31:0] ifid_inst;
    pc_idx_t     ifid_pc;
    pc_idx_t     ifid_pc_plus1;
    logic        ifid_valid;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetch_cnt, perf_stall_cnt, perf_flush_cnt;
`endif

    logic [31:0] rom [32];
    assign rom_inst = rom[rom_addr];

    always #5 clk = ~clk;

    if_fetch_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .jmp_en        (jmp_en),
        .jmp_target    (jmp_target),
        .rom_addr      (rom_addr),
        .rom_inst      (rom_inst),
        .ifid_inst     (ifid_inst),
        .ifid_pc       (ifid_pc),
        .ifid_pc_plus1 (ifid_pc_plus1),
        .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
`endif
    );

    int checks = 0;
    int failures = 0;

    // Reference model: architectural state as plain integers.
    int          m_pc, m_ifpc, m_plus1, m_valid;
    logic [31:0] m_inst;
    int          m_fc, m_sc, m_flc;

    typedef struct {
        bit rst; bit stall; bit br; int bt; bit jmp; int jt;
        int pc; int ifpc; int plus1; bit valid;
    } vec_t;

    vec_t vecs [20];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v >= 65535) ? 65535 : v + 1;
    endfunction

    task automatic model_edge(input bit r, input bit s, input bit b, input int bt,
                              input bit j, input int jt);
        if (r) begin
            m_pc = RESET_PC_DEF; m_ifpc = 0; m_plus1 = 0; m_valid = 0; m_inst = 32'h0;
            m_fc = 0; m_sc = 0; m_flc = 0;
        end else if (s) begin
            m_sc = sat(m_sc);
        end else if (b || j) begin
            m_ifpc  = m_pc;
            m_plus1 = (m_pc + 1) % 32;
            m_inst  = 32'h0;
            m_valid = 0;
            m_pc    = b ? bt : jt;
            m_flc   = sat(m_flc);
        end else begin
            m_inst  = rom[m_pc];
            m_ifpc  = m_pc;
            m_plus1 = (m_pc + 1) % 32;
            m_valid = 1;
            m_pc    = (m_pc + 1) % 32;
            m_fc    = sat(m_fc);
        end
    endtask

    task automatic do_cycle(input bit r, input bit s, input bit b, input int bt,
                            input bit j, input int jt, input bit cmp);
        @(negedge clk);
        rst = r; stall = s; br_taken = b; br_target = pc_idx_t'(bt);
        jmp_en = j; jmp_target = pc_idx_t'(jt);
        @(posedge clk);
        model_edge(r, s, b, bt, j, jt);
        #1;
        if (cmp) begin
            check("rom_addr", 32'(rom_addr), 32'(m_pc));
            check("ifid_pc", 32'(ifid_pc), 32'(m_ifpc));
            check("ifid_pc_plus1", 32'(ifid_pc_plus1), 32'(m_plus1));
            check("ifid_valid", 32'(ifid_valid), 32'(m_valid));
            check("ifid_inst", ifid_inst, m_inst);
`ifdef FETCH_PERF_EN
            check("perf_fetch", 32'(perf_fetch_cnt), 32'(m_fc));
            check("perf_stall", 32'(perf_stall_cnt), 32'(m_sc));
            check("perf_flush", 32'(perf_flush_cnt), 32'(m_flc));
`endif
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) do_cycle(0, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rom[i] = 32'hA000_0000 | i;
        m_pc = 0; m_ifpc = 0; m_plus1 = 0; m_valid = 0; m_inst = 0;
        m_fc = 0; m_sc = 0; m_flc = 0;

        //          rst stall br bt    jmp jt    pc    ifpc  plus1 valid
        vecs[0]  = '{1, 0, 0, 0,    0, 0,    0,    0,    0,    0};
        vecs[1]  = '{1, 0, 0, 0,    0, 0,    0,    0,    0,    0};
        vecs[2]  = '{0, 0, 0, 0,    0, 0,    1,    0,    1,    1};
        vecs[3]  = '{0, 0, 0, 0,    0, 0,    2,    1,    2,    1};
        vecs[4]  = '{0, 0, 0, 0,    0, 0,    3,    2,    3,    1};
        vecs[5]  = '{0, 0, 0, 0,    0, 0,    4,    3,    4,    1};
        vecs[6]  = '{0, 0, 0, 0,    0, 0,    5,    4,    5,    1};
        vecs[7]  = '{0, 1, 1, 3,    0, 0,    5,    4,    5,    1};
        vecs[8]  = '{0, 0, 0, 0,    0, 0,    6,    5,    6,    1};
        vecs[9]  = '{0, 0, 0, 0,    0, 0,    7,    6,    7,    1};
        vecs[10] = '{0, 0, 0, 0,    0, 0,    8,    7,    8,    1};
        vecs[11] = '{0, 0, 0, 0,    0, 0,    9,    8,    9,    1};
        vecs[12] = '{0, 0, 0, 0,    0, 0,    10,   9,    10,   1};
        vecs[13] = '{0, 0, 1, 11,   0, 0,    11,   10,   11,   0};
        vecs[14] = '{0, 0, 0, 0,    0, 0,    12,   11,   12,   1};
        vecs[15] = '{0, 0, 0, 0,    0, 0,    13,   12,   13,   1};
        vecs[16] = '{0, 0, 0, 0,    1, 9,    9,    13,   14,   0};
        vecs[17] = '{0, 0, 0, 0,    0, 0,    10,   9,    10,   1};
        vecs[18] = '{0, 0, 1, 12,   1, 9,    12,   10,   11,   0};
        vecs[19] = '{0, 0, 0, 0,    0, 0,    13,   12,   13,   1};

        // Directed vector table against hand-derived constants.
        for (int i = 0; i < 20; i++) begin
            do_cycle(vecs[i].rst, vecs[i].stall, vecs[i].br, vecs[i].bt,
                     vecs[i].jmp, vecs[i].jt, 1);
            check($sformatf("tbl%0d_pc", i), 32'(rom_addr), 32'(vecs[i].pc));
            check($sformatf("tbl%0d_ifpc", i), 32'(ifid_pc), 32'(vecs[i].ifpc));
            check($sformatf("tbl%0d_plus1", i), 32'(ifid_pc_plus1), 32'(vecs[i].plus1));
            check($sformatf("tbl%0d_valid", i), 32'(ifid_valid), 32'(vecs[i].valid));
            check($sformatf("tbl%0d_inst", i), ifid_inst,
                  vecs[i].valid ? (32'hA000_0000 | 32'(vecs[i].ifpc)) : 32'h0);
        end

        // Wrap-around 0x1F -> 0x00.
        do_cycle(0, 0, 0, 0, 1, 30, 1);
        idle(1);
        check("wrap_pre_pc", 32'(rom_addr), 32'd31);
        idle(1);
        check("wrap_pc", 32'(rom_addr), 32'd0);
        check("wrap_ifpc", 32'(ifid_pc), 32'd31);
        check("wrap_plus1", 32'(ifid_pc_plus1), 32'd0);

        // Reset dominates stall and redirect mid-operation.
        idle(3);
        do_cycle(1, 1, 1, 17, 1, 5, 1);
        check("rstmix_pc", 32'(rom_addr), 32'd0);
        check("rstmix_valid", 32'(ifid_valid), 32'd0);
        check("rstmix_inst", ifid_inst, 32'h0);
        check("rstmix_ifpc", 32'(ifid_pc), 32'd0);
        check("rstmix_plus1", 32'(ifid_pc_plus1), 32'd0);

        // Jump-to-self: bubble every iteration, pc stays put.
        idle(4);
        do_cycle(0, 0, 0, 0, 1, 4, 1);
        do_cycle(0, 0, 0, 0, 1, 4, 1);
        check("self_pc", 32'(rom_addr), 32'd4);
        check("self_valid", 32'(ifid_valid), 32'd0);

`ifdef FETCH_PERF_EN
        do_cycle(1, 0, 0, 0, 0, 0, 1);
        idle(5);
        do_cycle(0, 1, 0, 0, 0, 0, 1);
        do_cycle(0, 1, 1, 3, 0, 0, 1);
        do_cycle(0, 0, 1, 3, 0, 0, 1);
        check("perf_fetch_5", 32'(perf_fetch_cnt), 32'd5);
        check("perf_stall_2", 32'(perf_stall_cnt), 32'd2);
        check("perf_flush_1", 32'(perf_flush_cnt), 32'd1);
        for (int k = 0; k < 65540; k++) do_cycle(0, 0, 0, 0, 0, 0, (k % 1024) == 0);
        check("perf_fetch_sat", 32'(perf_fetch_cnt), 32'h0000_FFFF);
        idle(2);
        check("perf_fetch_hold", 32'(perf_fetch_cnt), 32'h0000_FFFF);
`endif

        // Random traffic against the model, including NOP words in the ROM.
        for (int i = 0; i < 32; i++) rom[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
        for (int k = 0; k < 3000; k++) begin
            do_cycle($urandom_range(0, 99) < 2,
                     $urandom_range(0, 99) < 25,
                     $urandom_range(0, 99) < 15, int'($urandom_range(0, 31)),
                     $urandom_range(0, 99) < 15, int'($urandom_range(0, 31)), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctrl.md
Name: if_fetch_ctrl

Overview:
Instruction-fetch controller for the 5-stage pipeline. It owns the PC register and drives the word address of the combinational instruction ROM (32 words, 5-bit index). It captures the returned instruction into the IF/ID pipeline register. It applies load-use stalls from the hazard unit and branch/jump redirects from the ID stage, squashing the wrong-path fetch on every redirect.

Parameters:
PC_W, 5, ROM word-index width; the PC is a word index, not a byte address.
INST_W, 32, instruction width.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
stall  in  1  hazard-unit hold request; freezes PC and IF/ID
br_taken  in  1  ID-stage branch resolved taken
br_target  in  PC_W  branch target word index
jmp_en  in  1  ID-stage jump
jmp_target  in  PC_W  jump target word index (instr_index[PC_W-1:0])
rom_addr  out  PC_W  ROM index; equals the PC register
rom_inst  in  INST_W  ROM data for rom_addr, same cycle (combinational)
ifid_inst  out  INST_W  registered instruction to ID
ifid_pc  out  PC_W  word index of ifid_inst
ifid_pc_plus1  out  PC_W  ifid_pc+1 mod 2^PC_W, for branch-target adder
ifid_valid  out  1  ifid_inst is a real fetch (0 = bubble/NOP)

Behaviour:
- Reset, when rst=1 at a clk edge: pc<=RESET_PC, ifid_inst<=0 (NOP), ifid_pc<=0, ifid_pc_plus1<=0, ifid_valid<=0. Reset dominates every other input, including mid-stall and mid-redirect.
- rom_addr = pc at all times, with no extra register. Latency is 1 cycle: an instruction at pc appears on ifid_* the cycle after pc is presented.
- Redirect is defined as br_taken | jmp_en.
- Per-edge priority, highest first:
  1. rst
  2. stall
  3. redirect
  4. sequential fetch
- stall=1: pc, ifid_inst, ifid_pc, ifid_pc_plus1 and ifid_valid all hold. Any redirect in that cycle is ignored; ID re-presents it while the branch is held.
- Redirect with stall=0:
  - pc <= br_target if br_taken, else jmp_target. br_taken wins when both are asserted.
  - IF/ID is flushed: ifid_inst<=0, ifid_valid<=0, ifid_pc<=pc, ifid_pc_plus1<=pc+1.
  - This gives one wrong-path slot squashed, with no delay slot.
- Sequential fetch: ifid_inst<=rom_inst, ifid_pc<=pc, ifid_pc_plus1<=pc+1, ifid_valid<=1, pc<=pc+1.
- Wrap-around: pc+1 is modulo 2^PC_W, so 31 -> 0. No error flag is raised.
- Redirect to the current or own PC, for example a jump-to-self: legal, gives a tight loop with a bubble every iteration.
- The block does not decode instructions; NOP words fetched from the ROM set ifid_valid=1.

Optional Feature:
Macro FETCH_PERF_EN.
- Defined: adds three 16-bit outputs, each reset to 0 and saturating at 16'hFFFF:
  - perf_fetch_cnt: increments per sequential fetch.
  - perf_stall_cnt: increments per cycle with stall=1 and rst=0.
  - perf_flush_cnt: increments per accepted redirect.
- Not defined: the ports and logic are absent, and fetch behaviour is identical.

Decomposition:
- Package fetch_pkg holds:
  - constants PC_W_DEF=5, INST_W_DEF=32, NOP_INST=32'h0000_0000, RESET_PC_DEF=0;
  - a typedef for the PC word index;
  - an enum for the next-PC select: NPC_SEQ, NPC_HOLD, NPC_BR, NPC_JMP.
- One sub-module, fetch_perf_cnt: a 16-bit saturating counter with en and synchronous rst. It is instantiated three times, only under FETCH_PERF_EN.

Test Plan:
- Reset held 2 cycles, then released with a straight-line ROM → rom_addr goes 0,1,2,3,4; ifid_pc lags by one cycle; ifid_valid=0 on the first cycle after release, 1 afterwards.
- Load-use stall: stall=1 for 1 cycle while ifid_pc=4 → rom_addr holds at 5 and ifid_inst/ifid_pc hold at 4 for that cycle; the next cycle delivers pc 5.
- Branch: br_taken=1, br_target=0x0B while pc=0x0A → next rom_addr=0x0B; ifid_inst=0 and ifid_valid=0; the following cycle ifid_pc=0x0B, ifid_valid=1.
- Jump loop: jmp_en=1, jmp_target=0x09 at pc=0x0D → rom_addr=0x09, one bubble; with br_taken=1, br_target=0x0C also asserted, the next pc is 0x0C.
- Wrap and reset mid-operation: run pc to 0x1F, then sequential → pc=0x00 with ifid_pc_plus1=0x00. Assert rst together with stall=1 and br_taken=1 → pc=RESET_PC, all ifid_* cleared.
- With FETCH_PERF_EN: 5 fetches, 2 stall cycles, 1 redirect → counters read 5/2/1. Preload perf_fetch_cnt near saturation: it stays at 16'hFFFF.
